// File: rtl/asymdata_inbuf_ctl_pkg.sv
// Shared state encoding, counter width and width-ratio helper for the asymmetric inbuf push sequencer.
package asymdata_ctl_pkg;

    localparam int ASYM_WCNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DONE  = 3'd3,
        ST_CLR   = 3'd4
    } asym_ctl_state_t;

    // Subwords per output word; returns 0 for a width pair that is not an integer ratio.
    function automatic int asym_ratio(input int in_w, input int out_w);
        if (in_w <= 0 || out_w <= 0 || (out_w % in_w) != 0) begin
            return 0;
        end
        return out_w / in_w;
    endfunction

endpackage

// File: rtl/asymdata_inbuf_ctl_tmo.sv
// Loadable idle-timeout counter: counts enabled cycles, expire is high on the
// enabled cycle that completes `limit` consecutive counts; clr restarts from zero.
module asymdata_ctl_tmo
    import asymdata_ctl_pkg::*;
#(
    parameter int CNT_W = ASYM_WCNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = en && (count == (limit - CNT_W'(1)));

endmodule

// File: rtl/asymdata_inbuf_ctl.sv
// Packet-framed push sequencer for DW_asymdata_inbuf: zero-latency push; s_ready low outside IDLE/FILL or when inbuf and FIFO are both full.
// Define ASYMDATA_INBUF_CTL_TMO_EN to force a flush after flush_tmo idle cycles on a partial word.
module asymdata_inbuf_ctl
    import asymdata_ctl_pkg::*;
#(
    parameter int in_width  = 8,
    parameter int out_width = 16,
    parameter int flush_tmo = 64
) (
    input  logic                   clk_push,
    input  logic                   rst_push_n,
    input  logic                   clr,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [in_width-1:0]    s_data,
    input  logic                   s_last,
    output logic                   push_req_n,
    output logic [in_width-1:0]    data_in,
    output logic                   flush_n,
    output logic                   init_push_n,
    input  logic                   fifo_full,
    input  logic                   inbuf_full,
    input  logic                   push_wd_n,
    output logic                   pkt_done,
    output logic [ASYM_WCNT_W-1:0] pkt_words,
    output logic                   tmo_flush
);

    localparam int K  = asym_ratio(in_width, out_width);
    localparam int CW = (K > 2) ? $clog2(K) : 1;

    if (K < 2) begin : g_bad_ratio
        $error("asymdata_inbuf_ctl: out_width/in_width must be an integer >= 2");
    end
    if (flush_tmo < 1 || flush_tmo > 65535) begin : g_bad_tmo
        $error("asymdata_inbuf_ctl: flush_tmo must be within 1..65535");
    end

    asym_ctl_state_t        state;
    asym_ctl_state_t        state_nxt;
    logic [CW-1:0]          cnt;
    logic [ASYM_WCNT_W-1:0] wcnt;
    logic [ASYM_WCNT_W-1:0] pkt_words_q;
    logic                   pkt_done_q;
    logic                   accept;
    logic                   word_end;
    logic                   flush_go;
    logic                   tmo_hit;
    logic                   tmo_mode;

    // clr wins over a same-cycle beat, so it is folded into the handshake itself.
    assign s_ready     = rst_push_n && !clr && (state == ST_IDLE || state == ST_FILL)
                         && !(inbuf_full && fifo_full);
    assign accept      = s_valid && s_ready;
    assign push_req_n  = !accept;
    assign data_in     = s_data;
    assign flush_go    = (state == ST_FLUSH) && !fifo_full;
    assign flush_n     = !(rst_push_n && flush_go);
    assign init_push_n = !(rst_push_n && state == ST_CLR);
    assign word_end    = (cnt == CW'(K - 1));
    assign pkt_done    = pkt_done_q;
    assign pkt_words   = pkt_words_q;

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = ST_CLR;
        end else begin
            case (state)
                ST_IDLE, ST_FILL: begin
                    if (accept) begin
                        if (!s_last)       state_nxt = ST_FILL;
                        else if (word_end) state_nxt = ST_DONE;
                        else               state_nxt = ST_FLUSH;
                    end else if (tmo_hit) begin
                        state_nxt = ST_FLUSH;
                    end
                end
                ST_FLUSH: if (flush_go) state_nxt = tmo_mode ? ST_IDLE : ST_DONE;
                ST_DONE:  state_nxt = ST_IDLE;
                ST_CLR:   state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_push) begin
        if (!rst_push_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            wcnt        <= '0;
            pkt_done_q  <= 1'b0;
            pkt_words_q <= '0;
        end else begin
            state      <= state_nxt;
            pkt_done_q <= (state == ST_DONE);
            if (clr || flush_go) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= word_end ? '0 : cnt + CW'(1);
            end
            // DONE is the cycle the inbuf reports the packet's final word.
            if (state == ST_DONE) begin
                pkt_words_q <= wcnt + ASYM_WCNT_W'(!push_wd_n);
            end
            if (clr || state == ST_DONE) begin
                wcnt <= '0;
            end else if (!push_wd_n) begin
                wcnt <= wcnt + ASYM_WCNT_W'(1);
            end
        end
    end

`ifdef ASYMDATA_INBUF_CTL_TMO_EN
    logic tmo_en;
    logic tmo_mode_q;
    logic tmo_flush_q;

    assign tmo_en = (state == ST_FILL) && (cnt != '0) && !accept;

    asymdata_ctl_tmo #(
        .CNT_W (ASYM_WCNT_W)
    ) u_tmo (
        .clk    (clk_push),
        .rst_n  (rst_push_n),
        .clr    (!tmo_en),
        .en     (tmo_en),
        .limit  (ASYM_WCNT_W'(flush_tmo)),
        .expire (tmo_hit)
    );

    // A timeout flush returns to IDLE without closing the packet.
    always_ff @(posedge clk_push) begin
        if (!rst_push_n || clr) begin
            tmo_mode_q  <= 1'b0;
            tmo_flush_q <= 1'b0;
        end else begin
            tmo_flush_q <= tmo_hit;
            if (tmo_hit)       tmo_mode_q <= 1'b1;
            else if (flush_go) tmo_mode_q <= 1'b0;
        end
    end

    assign tmo_mode  = tmo_mode_q;
    assign tmo_flush = tmo_flush_q;
`else
    assign tmo_hit   = 1'b0;
    assign tmo_mode  = 1'b0;
    assign tmo_flush = 1'b0;
`endif

endmodule

// File: tb/tb_asymdata_inbuf_ctl.sv
// Randomized packet bench for asymdata_inbuf_ctl with a behavioural inbuf and packet-level expectations.
module tb_asymdata_inbuf_ctl;

    localparam int IW  = 8;
    localparam int OW  = 16;
    localparam int K   = OW / IW;
    localparam int TMO = 4;

    logic          clk_push   = 1'b0;
    logic          rst_push_n = 1'b0;
    logic          clr        = 1'b0;
    logic          s_valid    = 1'b0;
    logic          s_last     = 1'b0;
    logic [IW-1:0] s_data     = '0;
    logic          fifo_full  = 1'b0;
    logic          inbuf_full = 1'b0;
    logic          push_wd_n  = 1'b1;
    logic          s_ready;
    logic          push_req_n;
    logic [IW-1:0] data_in;
    logic          flush_n;
    logic          init_push_n;
    logic          pkt_done;
    logic [15:0]   pkt_words;
    logic          tmo_flush;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int sub = 0;
    int push_cnt = 0, flush_cnt = 0, done_cnt = 0, tmo_cnt = 0, init_cnt = 0;
    int done_cyc = 0, flush_cyc = 0, tmo_cyc = 0;
    logic [IW-1:0] got_q[$];
    logic [IW-1:0] exp_q[$];

    always #5 clk_push = ~clk_push;

    asymdata_inbuf_ctl #(
        .in_width  (IW),
        .out_width (OW),
        .flush_tmo (TMO)
    ) dut (
        .clk_push    (clk_push),
        .rst_push_n  (rst_push_n),
        .clr         (clr),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .push_req_n  (push_req_n),
        .data_in     (data_in),
        .flush_n     (flush_n),
        .init_push_n (init_push_n),
        .fifo_full   (fifo_full),
        .inbuf_full  (inbuf_full),
        .push_wd_n   (push_wd_n),
        .pkt_done    (pkt_done),
        .pkt_words   (pkt_words),
        .tmo_flush   (tmo_flush)
    );

    always @(posedge clk_push) cyc <= cyc + 1;

    // Inbuf stand-in: packs K subwords per word, flush emits a partial word, init discards.
    always @(posedge clk_push) begin
        if (!rst_push_n || !init_push_n) begin
            sub       <= 0;
            push_wd_n <= 1'b1;
        end else if (!push_req_n) begin
            push_wd_n <= (sub == K - 1) ? 1'b0 : 1'b1;
            sub       <= (sub == K - 1) ? 0 : sub + 1;
        end else if (!flush_n && sub != 0) begin
            sub       <= 0;
            push_wd_n <= 1'b0;
        end else begin
            push_wd_n <= 1'b1;
        end
    end

    always @(negedge clk_push) begin
        if (push_req_n === 1'b0) begin push_cnt++; got_q.push_back(data_in); end
        if (flush_n === 1'b0) begin flush_cnt++; flush_cyc = cyc; end
        if (pkt_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (tmo_flush === 1'b1) begin tmo_cnt++; tmo_cyc = cyc; end
        if (init_push_n === 1'b0) init_cnt++;
    end

    task automatic step();
        @(posedge clk_push);
        #1;
    endtask

    // Sends n beats; pre beats of this packet were already pushed, carry words were already written.
    task automatic send_pkt(input int n, input int pre, input int carry, input int ff_stall, input bit fixed);
        int p0, f0, d0, last_c, w, exp_lat, exp_words, exp_fl;
        bit ok;
        p0 = push_cnt; f0 = flush_cnt; d0 = done_cnt; last_c = 0;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b0;
            if (!fixed) repeat ($urandom_range(0, 2)) step();
            s_valid = 1'b1;
            s_last  = (i == n - 1);
            s_data  = fixed ? IW'(8'h11 * (i + 1)) : IW'($urandom);
            #1;
            w = 0;
            while (s_ready !== 1'b1 && w < 50) begin step(); #1; w++; end
            if (w >= 50) begin
                tests++; fails++;
                $display("FAIL accept_wait: s_ready=%b required 1 within 50 cycles", s_ready);
            end
            exp_q.push_back(s_data);
            last_c = cyc;
            step();
        end
        s_valid = 1'b0; s_last = 1'b0;
        if (ff_stall > 0) begin
            fifo_full = 1'b1;
            repeat (ff_stall) step();
            fifo_full = 1'b0;
        end
        w = 0;
        while (done_cnt == d0 && w < 60) begin step(); w++; end
        exp_words = carry + (pre + n + K - 1) / K;
        exp_fl    = ((pre + n) % K != 0) ? 1 : 0;
        exp_lat   = (exp_fl != 0) ? 3 + ff_stall : 2;
        tests++;
        if (done_cnt != d0 + 1) begin fails++; $display("FAIL pkt_done_count: got %0d pulses, required 1", done_cnt - d0); end
        tests++;
        if (done_cyc - last_c != exp_lat) begin fails++; $display("FAIL pkt_done_latency: got %0d cycles, required %0d", done_cyc - last_c, exp_lat); end
        tests++;
        if (pkt_words !== 16'(exp_words)) begin fails++; $display("FAIL pkt_words: got %0d, required %0d", pkt_words, exp_words); end
        tests++;
        if (pkt_done !== 1'b0) begin fails++; $display("FAIL pkt_done_width: got %b after pulse, required 0", pkt_done); end
        tests++;
        if (push_cnt - p0 != n) begin fails++; $display("FAIL push_count: got %0d, required %0d", push_cnt - p0, n); end
        tests++;
        if (flush_cnt - f0 != exp_fl) begin fails++; $display("FAIL flush_count: got %0d, required %0d", flush_cnt - f0, exp_fl); end
        ok = (got_q.size() == exp_q.size());
        if (ok) foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) ok = 1'b0;
        tests++;
        if (!ok) begin fails++; $display("FAIL push_data: got %0d beats %p, required %0d beats %p", got_q.size(), got_q, exp_q.size(), exp_q); end
        step(); step();
        tests++;
        if (pkt_words !== 16'(exp_words)) begin fails++; $display("FAIL pkt_words_hold: got %0d, required %0d", pkt_words, exp_words); end
    endtask

    task automatic test_reset();
        rst_push_n = 1'b0; s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b0;
        #1;
        tests++;
        if (s_ready !== 1'b0) begin fails++; $display("FAIL reset_s_ready: got %b, required 0", s_ready); end
        tests++;
        if (push_req_n !== 1'b1) begin fails++; $display("FAIL reset_push_req_n: got %b, required 1", push_req_n); end
        repeat (3) step();
        tests++;
        if (flush_n !== 1'b1 || init_push_n !== 1'b1) begin fails++; $display("FAIL reset_ctl: flush_n=%b init_push_n=%b, required 1 1", flush_n, init_push_n); end
        tests++;
        if (pkt_done !== 1'b0 || pkt_words !== 16'd0 || tmo_flush !== 1'b0) begin
            fails++; $display("FAIL reset_regs: pkt_done=%b pkt_words=%0d tmo_flush=%b, required 0 0 0", pkt_done, pkt_words, tmo_flush);
        end
        tests++;
        if (s_ready !== 1'b0 || push_cnt != 0) begin fails++; $display("FAIL reset_hold: s_ready=%b pushes=%0d, required 0 0", s_ready, push_cnt); end
        s_valid = 1'b0; rst_push_n = 1'b1;
        step();
        tests++;
        if (s_ready !== 1'b1) begin fails++; $display("FAIL idle_s_ready: got %b, required 1", s_ready); end
    endtask

    task automatic test_full_stall();
        int p0;
        p0 = push_cnt;
        inbuf_full = 1'b1; fifo_full = 1'b1;
        s_valid = 1'b1; s_last = 1'b0; s_data = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (s_ready !== 1'b0 || push_req_n !== 1'b1) begin
                fails++; $display("FAIL full_stall: s_ready=%b push_req_n=%b, required 0 1", s_ready, push_req_n);
            end
            step();
        end
        tests++;
        if (push_cnt != p0) begin fails++; $display("FAIL full_stall_push: got %0d pushes, required 0", push_cnt - p0); end
        fifo_full = 1'b0;
        #1;
        tests++;
        if (s_ready !== 1'b1 || push_req_n !== 1'b0) begin
            fails++; $display("FAIL full_release: s_ready=%b push_req_n=%b, required 1 0", s_ready, push_req_n);
        end
        step();
        inbuf_full = 1'b0;
        send_pkt(3, 1, 0, 0, 1'b0);
    endtask

    task automatic test_clr();
        int p0, i0;
        s_valid = 1'b1; s_last = 1'b0; s_data = 8'h5A;
        #1;
        tests++;
        if (s_ready !== 1'b1) begin fails++; $display("FAIL clr_first_beat: s_ready=%b, required 1", s_ready); end
        step();
        p0 = push_cnt; i0 = init_cnt;
        s_data = 8'h77; clr = 1'b1;
        #1;
        tests++;
        if (s_ready !== 1'b0 || push_req_n !== 1'b1) begin
            fails++; $display("FAIL clr_priority: s_ready=%b push_req_n=%b, required 0 1", s_ready, push_req_n);
        end
        step();
        clr = 1'b0; s_valid = 1'b0;
        #1;
        tests++;
        if (init_push_n !== 1'b0) begin fails++; $display("FAIL clr_init: init_push_n=%b, required 0", init_push_n); end
        step();
        tests++;
        if (init_push_n !== 1'b1) begin fails++; $display("FAIL clr_init_width: init_push_n=%b, required 1", init_push_n); end
        tests++;
        if (push_cnt != p0 || init_cnt != i0 + 1) begin
            fails++; $display("FAIL clr_counts: pushes=%0d inits=%0d, required 0 1", push_cnt - p0, init_cnt - i0);
        end
        send_pkt(4, 0, 0, 0, 1'b1);
    endtask

    task automatic test_random();
        for (int p = 0; p < 20; p++) begin
            send_pkt($urandom_range(1, 9), 0, 0, $urandom_range(0, 3), 1'b0);
        end
    endtask

    task automatic test_timeout();
        int d0, f0, t0, c0, w;
        d0 = done_cnt; f0 = flush_cnt; t0 = tmo_cnt;
        s_valid = 1'b1; s_last = 1'b0; s_data = IW'($urandom);
        #1;
        c0 = cyc;
        step();
        s_valid = 1'b0;
`ifdef ASYMDATA_INBUF_CTL_TMO_EN
        w = 0;
        while (tmo_cnt == t0 && w < 30) begin step(); w++; end
        tests++;
        if (tmo_cnt != t0 + 1) begin fails++; $display("FAIL tmo_pulse: got %0d pulses, required 1", tmo_cnt - t0); end
        tests++;
        if (tmo_cyc - c0 != TMO + 1) begin fails++; $display("FAIL tmo_latency: got %0d cycles, required %0d", tmo_cyc - c0, TMO + 1); end
        tests++;
        if (flush_cnt != f0 + 1 || flush_cyc != tmo_cyc) begin
            fails++; $display("FAIL tmo_flush_n: flushes=%0d at cycle %0d, required 1 at cycle %0d", flush_cnt - f0, flush_cyc, tmo_cyc);
        end
        repeat (6) step();
        tests++;
        if (done_cnt != d0) begin fails++; $display("FAIL tmo_no_done: got %0d pulses, required 0", done_cnt - d0); end
        send_pkt(1, 0, 1, 0, 1'b0);
`else
        w = 0;
        repeat (20) begin step(); w++; end
        tests++;
        if (flush_cnt != f0 || done_cnt != d0) begin
            fails++; $display("FAIL partial_wait: flushes=%0d done=%0d after %0d idle cycles, required 0 0", flush_cnt - f0, done_cnt - d0, w);
        end
        tests++;
        if (tmo_cnt != t0) begin fails++; $display("FAIL tmo_tied: got %0d pulses, required 0", tmo_cnt - t0); end
        send_pkt(1, 1, 0, 0, 1'b0);
`endif
    endtask

    initial begin
        test_reset();
        send_pkt(4, 0, 0, 0, 1'b1);
        send_pkt(3, 0, 0, 0, 1'b1);
        send_pkt(3, 0, 0, 5, 1'b1);
        test_full_stall();
        test_clr();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/asymdata_inbuf_ctl.md
# asymdata_inbuf_ctl

Packet-framed push sequencer that sits in front of `DW_asymdata_inbuf` in the push clock domain. It converts an upstream valid/ready stream with an end-of-packet flag into the inbuf's `push_req_n`/`flush_n`/`init_push_n` controls. Every packet ends on an output-word boundary, and the block never pushes or flushes into a full FIFO. It also reports per-packet output-word counts to the packet scheduler.

## Interface
Parameters:
- `in_width`, 8: upstream subword width; equals the inbuf `in_width`.
- `out_width`, 16: inbuf output word width; `out_width/in_width` = K, an integer ≥ 2.
- `flush_tmo`, 64: idle cycles with a partial word held before a forced flush (1..65535).

Ports:
- `clk_push` in 1: the single clock.
- `rst_push_n` in 1: reset; synchronous, active-low.
- `clr` in 1: soft clear request, single-cycle pulse.
- `s_valid` in 1: upstream subword valid.
- `s_ready` out 1: upstream subword accepted when high together with `s_valid`.
- `s_data` in `in_width`: upstream subword.
- `s_last` in 1: marks the last subword of a packet.
- `push_req_n` out 1: to inbuf `push_req_n`.
- `data_in` out `in_width`: to inbuf `data_in`; equals `s_data`.
- `flush_n` out 1: to inbuf `flush_n`.
- `init_push_n` out 1: to inbuf `init_push_n`.
- `fifo_full` in 1: downstream FIFO full.
- `inbuf_full` in 1: from inbuf.
- `push_wd_n` in 1: from inbuf; active-low word written to the FIFO.
- `pkt_done` out 1: one-cycle pulse when a packet is completely written.
- `pkt_words` out 16: output words of the last completed packet; valid while `pkt_done` is high and held until the next pulse.
- `tmo_flush` out 1: one-cycle pulse when a timeout forced a flush.

## Operation
- Internal subword count `cnt` runs 0..K-1.
  - `cnt` increments on each accepted beat and wraps K-1→0.
  - `cnt` clears on reset, `clr` or flush.
- Accept rule:
  - `s_ready` = state∈{IDLE,FILL} && !(`inbuf_full` && `fifo_full`).
  - `push_req_n` = !(`s_valid` && `s_ready`), combinational.
- Word counter `wcnt` (16-bit, wraps):
  - Increments on each `push_wd_n`=0 cycle.
  - On `pkt_done`, `pkt_words` ← `wcnt` plus that cycle's word; `wcnt` then restarts at 0.
- FSM states: IDLE, FILL, FLUSH, DONE, CLR.
  - IDLE: first accepted beat → FILL. If that beat also has `s_last`, apply the FILL rules to it the same cycle.
  - FILL, accepted beat with `s_last`:
    - If it completes a word (`cnt`=K-1) → DONE.
    - Otherwise → FLUSH.
  - FILL, no `s_last`: stay in FILL.
  - FLUSH:
    - `flush_n`=0 in every FLUSH cycle where `fifo_full`=0; the state leaves the next cycle → DONE.
    - While `fifo_full`=1: hold FLUSH with `flush_n`=1.
  - DONE: waits one cycle for the inbuf's registered `push_wd_n`, pulses `pkt_done` that cycle, then → IDLE.
  - CLR: `init_push_n`=0 for exactly one cycle, then → IDLE. `s_ready`=0 in CLR.
- `clr` from any state → CLR next cycle. `clr` has priority over a same-cycle accept: the beat is not accepted.
- Flush with `cnt`=0 never occurs.
- `pkt_done` is not asserted for timeout flushes.

## Timing
- Reset values: `s_ready`=0, `push_req_n`=1, `flush_n`=1, `init_push_n`=1, `pkt_done`=0, `pkt_words`=0, `tmo_flush`=0, state=IDLE, `cnt`=0, `wcnt`=0.
- `s_ready` is forced to 0 while `rst_push_n`=0.
- Push latency is zero: the beat appears at the inbuf the cycle it is accepted.
- `pkt_done` latency:
  - Last beat completes a word: 2 cycles after the last beat.
  - Last beat leaves a partial word: 3 cycles after the last beat, plus any `fifo_full` stall cycles.
- `flush_n`, `push_req_n` and `s_ready` are combinational from state/inputs. `pkt_done`, `pkt_words` and `tmo_flush` are registered.
- Reset mid-packet discards `cnt`, `wcnt` and state. The inbuf is reset by its own reset.

## Configuration
- Macro `ASYMDATA_INBUF_CTL_TMO_EN`.
- Defined:
  - In FILL with `cnt`≠0, an idle counter counts cycles without an accepted beat and clears on any accept.
  - Reaching `flush_tmo` → FLUSH, with a `tmo_flush` pulse on entry.
  - After the flush → IDLE directly, with no DONE and no `pkt_done`. `wcnt` is kept, so the packet continues.
- Undefined:
  - There is no idle counter, and `tmo_flush` is tied to 0.
  - A partial word waits indefinitely for `s_last`.

## Structure
- Package `asymdata_ctl_pkg`:
  - State enum `asym_ctl_state_t`.
  - Function `asym_ratio(in_w, out_w)`, returning K, with an elaboration check that K is an integer ≥ 2.
  - Localparam `ASYM_WCNT_W` = 16.
- One sub-module, `asymdata_ctl_tmo`: a loadable idle-timeout counter with `clr`/`en`/`expire`. It is instantiated only under the macro.

## Test plan
All scenarios use `in_width`=8, `out_width`=16.
- 4-beat packet (0x11,0x22,0x33,0x44 with `s_last`): 4 pushes, no `flush_n` low, `pkt_done` 2 cycles after the last beat, `pkt_words`=2.
- 3-beat packet: the third beat → FLUSH, `flush_n` low for 1 cycle, `pkt_done` with `pkt_words`=2.
- 3-beat packet with `fifo_full`=1 during FLUSH for 5 cycles: `flush_n` stays 1 for those cycles, then asserts once; `pkt_done` is delayed by 5 cycles.
- `inbuf_full`=1 && `fifo_full`=1: `s_ready`=0 and `push_req_n`=1 held; the stall releases the cycle `fifo_full` drops.
- `clr` in the same cycle as a valid beat mid-packet: beat not accepted, `init_push_n` low for 1 cycle, `cnt`=0, next packet counts from 0.
- With the macro and `flush_tmo`=4: 1 beat then idle → `tmo_flush` and `flush_n` low after 4 idle cycles, no `pkt_done`. A later single `s_last` beat yields `pkt_words`=2.
